// File: rtl/counter_arbiter.sv
// Round-robin arbiter that time-shares one external counter between NUM_REQ
// requesters, loading the winner's interval length and pulsing done at max.
module counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     cnt_enable,
  output logic                     cnt_clear,
  output logic                     cnt_wrap,
  output logic [WIDTH-1:0]         cnt_max,
  input  logic                     cnt_at_max,
  input  logic [WIDTH-1:0]         cnt_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic [WIDTH-1:0] len_arr [NUM_REQ];
  logic             owner_req;
  logic             unused_count;

  // First set request strictly after ptr, wrapping; ptr itself has lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [SUM_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, ptr} + SUM_W'(k);
      if (idx >= SUM_W'(NUM_REQ)) idx = idx - SUM_W'(NUM_REQ);
      if (r[idx[IDX_W-1:0]]) pick = idx[IDX_W-1:0];
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    assign len_arr[i] = req_len[i*WIDTH +: WIDTH];
  end

  assign win          = rr_pick(req, rr_ptr);
  assign owner_req    = req[rr_ptr];
  assign cnt_wrap     = 1'b0;
  assign unused_count = ^cnt_count;

  // Enable drops in the same cycle at_max rises so the counter freezes at max.
  assign cnt_enable = (state == RUN) && !cnt_at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      cnt_clear <= 1'b0;
      cnt_max   <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= onehot(win);
            cnt_max   <= len_arr[win];
            rr_ptr    <= win;
            busy      <= 1'b1;
            cnt_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (!owner_req) begin
            state <= ABORT;
          end else begin
            cnt_clear <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          // An early request drop wins over a simultaneous at_max.
          if (!owner_req) begin
            cnt_clear <= 1'b1;
            state     <= ABORT;
          end else if (cnt_at_max) begin
            done      <= grant;
            cnt_clear <= 1'b1;
            state     <= DONE;
          end
        end
        DONE, ABORT: begin
          done      <= '0;
          grant     <= '0;
          busy      <= 1'b0;
          cnt_clear <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          done      <= '0;
          grant     <= '0;
          busy      <= 1'b0;
          cnt_clear <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter with a behavioural counter and a round-robin
// reference model derived from the interval timing rules.
module tb_counter_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_len = '0;
  logic [N-1:0]   grant, done;
  logic           busy, cnt_enable, cnt_clear, cnt_wrap;
  logic [W-1:0]   cnt_max;
  logic           cnt_at_max;
  logic [W-1:0]   cnt_count;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_ptr  = N - 1;
  int lens [N];

  counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .cnt_wrap(cnt_wrap),
    .cnt_max(cnt_max), .cnt_at_max(cnt_at_max), .cnt_count(cnt_count)
  );

  always #5 clk = ~clk;

  // External counter: synchronous clear, holds at max (wrap is tied off).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_count <= '0;
    else if (cnt_clear) cnt_count <= '0;
    else if (cnt_enable && cnt_count != cnt_max) cnt_count <= cnt_count + 1'b1;
  end
  assign cnt_at_max = (cnt_count == cnt_max);

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [N*W-1:0] pack_lens();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(lens[i]);
    return v;
  endfunction

  function automatic int rr_model(input logic [N-1:0] mask, input int ptr);
    for (int k = 1; k <= N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_ptr = N - 1;
  endtask

  // Called at a negedge with the DUT idle; drives one uncontested interval.
  task automatic run_interval(input int who, input int len, input bit chg, input string name);
    logic [2*N+2:0] obs, expv;
    for (int i = 0; i < N; i++) lens[i] = $urandom_range(0, 15);
    lens[who] = len;
    req_len = pack_lens();
    req = oh(who);
    for (int c = 1; c <= len + 4; c++) begin
      @(negedge clk);
      obs  = {grant, done, busy, cnt_clear, cnt_enable};
      expv = {(c <= len + 3) ? oh(who) : N'(0),
              (c == len + 3) ? oh(who) : N'(0),
              1'(c <= len + 3),
              1'(c == 1 || c == len + 3),
              1'(c >= 2 && c <= len + 1)};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s cycle=%0d {grant,done,busy,clr,en} got=%b want=%b", name, c, obs, expv);
      end
      if (c == 1) begin
        n_checks++;
        if (cnt_max !== W'(len)) begin
          n_fail++;
          $display("FAIL %s cnt_max got=%0d want=%0d", name, cnt_max, len);
        end
      end
      if (c == len + 3) begin
        n_checks++;
        if (cnt_count !== W'(len)) begin
          n_fail++;
          $display("FAIL %s count_at_done got=%0d want=%0d", name, cnt_count, len);
        end
        req = '0;
      end
      if (chg && c == 3) begin
        lens[who] = len + 5;
        req_len = pack_lens();
      end
    end
    mdl_ptr = who;
  endtask

  task automatic test_reset();
    logic [3*N+W+3:0] obs;
    @(negedge clk);
    obs = {grant, done, busy, cnt_clear, cnt_enable, cnt_wrap, cnt_max, N'(0)};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    rst = 1'b0;
    mdl_ptr = N - 1;
    lens[1] = 20;
    req_len = pack_lens();
    req = 4'b0010;
    repeat (5) @(negedge clk);
    n_checks++;
    if (cnt_enable !== 1'b1 || grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_run_state en=%b grant=%b want en=1 grant=0010", cnt_enable, grant);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({grant, done, busy, cnt_enable, cnt_clear} !== '0) begin
      n_fail++;
      $display("FAIL async_reset grant=%b done=%b busy=%b en=%b clr=%b want all 0",
               grant, done, busy, cnt_enable, cnt_clear);
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    mdl_ptr = N - 1;
    run_interval(3, 3, 1'b0, "post_reset");
  endtask

  task automatic test_single();
    run_interval(1, 5, 1'b0, "single_len5");
  endtask

  task automatic test_zero_len();
    run_interval(0, 0, 1'b0, "zero_len");
  endtask

  task automatic test_len_change();
    run_interval(0, 4, 1'b1, "len_change");
  endtask

  task automatic test_round_robin();
    int seen, last_c, exp_w;
    do_reset();
    for (int i = 0; i < N; i++) lens[i] = 2;
    req_len = pack_lens();
    req = '1;
    seen = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && seen < 5; c++) begin
      @(negedge clk);
      if (done !== '0) begin
        exp_w = rr_model('1, mdl_ptr);
        n_checks++;
        if (done !== oh(exp_w)) begin
          n_fail++;
          $display("FAIL rr_order idx=%0d done got=%b want=%b", seen, done, oh(exp_w));
        end
        n_checks++;
        if ((seen == 0 && c != 5) || (seen != 0 && c - last_c != 6)) begin
          n_fail++;
          $display("FAIL rr_spacing idx=%0d cycle got=%0d prev=%0d want gap 6 (first at 5)", seen, c, last_c);
        end
        mdl_ptr = exp_w;
        last_c = c;
        seen++;
        if (seen == 5) req = '0;
      end
    end
    n_checks++;
    if (seen != 5) begin
      n_fail++;
      $display("FAIL rr_timeout done pulses got=%0d want=5", seen);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_fail++;
      $display("FAIL rr_idle busy=%b grant=%b want 0", busy, grant);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < N; i++) lens[i] = 1;
    lens[2] = 10;
    req_len = pack_lens();
    req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100 || cnt_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_grant grant=%b clr=%b want 0100/1", grant, cnt_clear);
    end
    @(negedge clk);
    req = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cnt_enable !== 1'b1 || grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_run3 en=%b grant=%b want 1/0100", cnt_enable, grant);
    end
    req = 4'b1000;
    @(negedge clk);
    n_checks++;
    if ({grant, done, busy, cnt_clear, cnt_enable} !== {4'b0100, 4'b0000, 3'b110}) begin
      n_fail++;
      $display("FAIL abort_state grant=%b done=%b busy=%b clr=%b en=%b want 0100 0000 1 1 0",
               grant, done, busy, cnt_clear, cnt_enable);
    end
    @(negedge clk);
    n_checks++;
    if (grant !== '0 || busy !== 1'b0 || done !== '0) begin
      n_fail++;
      $display("FAIL abort_idle grant=%b busy=%b done=%b want 0", grant, busy, done);
    end
    mdl_ptr = 2;
    @(negedge clk);
    n_checks++;
    if (grant !== oh(rr_model(4'b1000, mdl_ptr))) begin
      n_fail++;
      $display("FAIL abort_next_grant got=%b want=1000", grant);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== '0) begin
      n_fail++;
      $display("FAIL abort_early_done got=%b want=0000", done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 4'b1000 || cnt_count !== W'(1)) begin
      n_fail++;
      $display("FAIL abort_next_done done=%b count=%0d want 1000/1", done, cnt_count);
    end
    req = '0;
    mdl_ptr = 3;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    int w, el, k;
    pend = '0;
    for (int it = 0; it < 25; it++) begin
      if (pend == '0) pend = N'($urandom_range(1, (1 << N) - 1));
      else pend |= N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) lens[i] = $urandom_range(0, 6);
      req_len = pack_lens();
      req = pend;
      w = rr_model(pend, mdl_ptr);
      el = lens[w];
      @(negedge clk);
      n_checks++;
      if (grant !== oh(w) || cnt_max !== W'(el)) begin
        n_fail++;
        $display("FAIL rand_grant it=%0d grant=%b max=%0d want %b/%0d", it, grant, cnt_max, oh(w), el);
      end
      mdl_ptr = w;
      lens[w] = $urandom_range(0, 6);
      req_len = pack_lens();
      pend |= N'($urandom_range(0, (1 << N) - 1));
      req = pend;
      k = 0;
      while (k < el + 8) begin
        @(negedge clk);
        k++;
        if (done !== '0) break;
      end
      n_checks++;
      if (k != el + 2 || done !== oh(w) || cnt_count !== W'(el)) begin
        n_fail++;
        $display("FAIL rand_done it=%0d cycles=%0d done=%b count=%0d want %0d/%b/%0d",
                 it, k, done, cnt_count, el + 2, oh(w), el);
      end
      pend &= ~oh(w);
      req = pend;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || grant !== '0) begin
        n_fail++;
        $display("FAIL rand_bubble it=%0d busy=%b grant=%b want 0", it, busy, grant);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_len_change();
    test_round_robin();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
